// File: rtl/bus_port_fifo.sv
// Per-device bus port: TX/RX first-word-fall-through FIFOs
// with inbound destination checking and saturating error counters.
module bus_port_fifo #(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16,
  parameter int depth   = 8,
  parameter int id      = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tx_wr,
  input  logic [pckg_sz-1:0]         tx_data,
  output logic                       tx_full,
  output logic [$clog2(depth):0]     tx_count,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  input  logic                       rx_rd,
  output logic [pckg_sz-1:0]         rx_data,
  output logic                       rx_valid,
  output logic [$clog2(depth):0]     rx_count,
  output logic [7:0]                 ovf_cnt,
  output logic [7:0]                 mis_cnt,
  output logic                       udf_err
);

  localparam int AW = $clog2(depth);
  localparam logic [7:0] MY_ID = 8'(id);
  localparam logic [7:0] BCAST = 8'hFF;

  if (pckg_sz < 9 || depth < 2 || (depth & (depth - 1)) != 0)
    $error("bus_port_fifo: bad pckg_sz/depth");
  if (id >= drvrs && id != 255)
    $error("bus_port_fifo: id out of range");

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;

  logic tx_empty, rx_empty, rx_full;
  logic tx_we, tx_re, rx_we, rx_re;
  logic [7:0] dst;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) &&
                    (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) &&
                    (rx_wp[AW-1:0] == rx_rp[AW-1:0]);

  assign tx_we = tx_wr & ~tx_full;
  assign tx_re = pop & ~tx_empty;
  assign rx_we = push & ~rx_full;
  assign rx_re = rx_rd & ~rx_empty;

  assign dst = D_push[pckg_sz-1:pckg_sz-8];

  assign pndng    = ~tx_empty;
  assign rx_valid = ~rx_empty;
  assign tx_count = tx_wp - tx_rp;
  assign rx_count = rx_wp - rx_rp;
  assign D_pop    = tx_empty ? '0 : tx_mem[tx_rp[AW-1:0]];
  assign rx_data  = rx_empty ? '0 : rx_mem[rx_rp[AW-1:0]];

  // Storage needs no reset: outputs are gated by the empty flags.
  always_ff @(posedge clk) begin
    if (tx_we) tx_mem[tx_wp[AW-1:0]] <= tx_data;
    if (rx_we) rx_mem[rx_wp[AW-1:0]] <= D_push;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wp   <= '0;
      tx_rp   <= '0;
      rx_wp   <= '0;
      rx_rp   <= '0;
      ovf_cnt <= '0;
      mis_cnt <= '0;
      udf_err <= 1'b0;
    end else begin
      if (tx_we) tx_wp <= tx_wp + 1'b1;
      if (tx_re) tx_rp <= tx_rp + 1'b1;
      if (rx_we) rx_wp <= rx_wp + 1'b1;
      if (rx_re) rx_rp <= rx_rp + 1'b1;
      if (push && rx_full && ovf_cnt != 8'hFF)
        ovf_cnt <= ovf_cnt + 1'b1;
      if (push && dst != MY_ID && dst != BCAST &&
          mis_cnt != 8'hFF)
        mis_cnt <= mis_cnt + 1'b1;
      if ((pop && tx_empty) || (rx_rd && rx_empty))
        udf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_port_fifo.sv
// Directed testbench for bus_port_fifo (depth=4, pckg_sz=16, id=2).
module tb_bus_port_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_wr, pop, push, rx_rd;
  logic [15:0] tx_data, D_push;
  logic        tx_full, pndng, rx_valid, udf_err;
  logic [15:0] D_pop, rx_data;
  logic [2:0]  tx_count, rx_count;
  logic [7:0]  ovf_cnt, mis_cnt;

  int checks = 0;
  int failures = 0;

  bus_port_fifo #(.drvrs(4), .pckg_sz(16), .depth(4), .id(2)) dut (
    .clk(clk), .reset(reset),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .tx_count(tx_count), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .rx_rd(rx_rd), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_count(rx_count), .ovf_cnt(ovf_cnt),
    .mis_cnt(mis_cnt), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tx_wr = 0; pop = 0; push = 0; rx_rd = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    tick();
    tick();
    reset = 1;
    tick();
  endtask

  initial begin
    tx_data = '0; D_push = '0;
    do_reset();

    // reset / idle
    chk("rst_pndng", pndng, 0);
    chk("rst_dpop", D_pop, 16'h0000);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_rxd", rx_data, 0);
    chk("rst_txc", tx_count, 0);
    chk("rst_full", tx_full, 0);
    chk("rst_ovf", ovf_cnt, 0);
    chk("rst_mis", mis_cnt, 0);
    chk("rst_udf", udf_err, 0);

    // TX fill with one dropped write
    for (int i = 1; i <= 5; i++) begin
      tx_wr = 1; tx_data = 16'h0100 + 16'(i);
      tick();
    end
    tx_wr = 0;
    chk("fill_full", tx_full, 1);
    chk("fill_cnt", tx_count, 4);
    for (int i = 1; i <= 4; i++) begin
      chk("fill_dpop", D_pop, 32'h0100 + 32'(i));
      pop = 1;
      tick();
      pop = 0;
    end
    chk("drain_pndng", pndng, 0);
    chk("drain_cnt", tx_count, 0);
    chk("drain_dpop", D_pop, 0);
    chk("drain_udf", udf_err, 0);

    // streaming across pointer wrap
    tx_wr = 1; tx_data = 16'h1000;
    tick();
    for (int k = 0; k < 20; k++) begin
      tx_wr = 1; pop = 1; tx_data = 16'h1001 + 16'(k);
      chk("strm_dpop", D_pop, 32'h1000 + 32'(k));
      tick();
      chk("strm_cnt", tx_count, 1);
    end
    idle();
    chk("strm_last", D_pop, 16'h1014);
    pop = 1;
    tick();
    pop = 0;
    chk("strm_empty", pndng, 0);

    // async reset mid-stream
    for (int i = 0; i < 3; i++) begin
      tx_wr = 1; tx_data = 16'h0A00 + 16'(i);
      tick();
    end
    tx_wr = 0;
    chk("arst_pre", tx_count, 3);
    #2 reset = 0;
    #1;
    chk("arst_cnt", tx_count, 0);
    chk("arst_pndng", pndng, 0);
    chk("arst_dpop", D_pop, 0);
    reset = 1;
    tick();
    chk("arst_post", pndng, 0);

    // RX overflow with read collision
    for (int i = 1; i <= 4; i++) begin
      push = 1; D_push = 16'h0210 + 16'(i);
      tick();
    end
    chk("rx_cnt4", rx_count, 4);
    chk("rx_head", rx_data, 16'h0211);
    push = 1; D_push = 16'h0215; rx_rd = 1;
    tick();
    idle();
    chk("ovf_cnt", ovf_cnt, 1);
    chk("ovf_rxc", rx_count, 3);
    chk("ovf_mis", mis_cnt, 0);
    for (int i = 2; i <= 4; i++) begin
      chk("ovf_rd", rx_data, 32'h0210 + 32'(i));
      rx_rd = 1;
      tick();
      rx_rd = 0;
    end
    chk("ovf_rxv", rx_valid, 0);
    chk("ovf_udf", udf_err, 0);

    // misroute and broadcast
    push = 1; D_push = 16'h0300;
    tick();
    push = 0;
    chk("mis_1", mis_cnt, 1);
    chk("mis_stored", rx_data, 16'h0300);
    push = 1; D_push = 16'hFF00;
    tick();
    D_push = 16'h0200;
    tick();
    push = 0;
    chk("mis_keep", mis_cnt, 1);
    chk("mis_rxc", rx_count, 3);
    chk("mis_d0", rx_data, 16'h0300);
    rx_rd = 1;
    tick();
    chk("mis_d1", rx_data, 16'hFF00);
    tick();
    chk("mis_d2", rx_data, 16'h0200);
    tick();
    rx_rd = 0;
    chk("mis_empty", rx_valid, 0);

    // TX underflow
    pop = 1;
    tick();
    pop = 0;
    chk("udf_tx", udf_err, 1);
    chk("udf_txc", tx_count, 0);
    chk("udf_pndng", pndng, 0);
    tx_wr = 1; tx_data = 16'h0B0B;
    tick();
    tx_wr = 0;
    chk("udf_txd", D_pop, 16'h0B0B);
    pop = 1;
    tick();
    pop = 0;
    chk("udf_sticky", udf_err, 1);

    // RX underflow on its own
    do_reset();
    chk("udf_clr", udf_err, 0);
    rx_rd = 1;
    tick();
    rx_rd = 0;
    chk("udf_rx", udf_err, 1);
    chk("udf_rxc", rx_count, 0);
    push = 1; D_push = 16'h0277;
    tick();
    push = 0;
    chk("udf_rxd", rx_data, 16'h0277);
    chk("udf_rx_sticky", udf_err, 1);
    do_reset();
    chk("udf_final", udf_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
